mem_arbiter: RTL

Two-requester arbiter and sequencer for the shared single-port data memory behind the load/store unit. Requester 0 is the core LSU path. Requester 1 is the debug/program-loader port. The block accepts one transaction at a time with a valid/ready handshake, grants round-robin, and drives the memory port with a registered request. It returns read data or a write acknowledge on a one-cycle response strobe to the requester that owns the transaction.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_pick2.sv | 41 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the two-requester data-memory arbiter:
//   - arb_state_e : sequencer states (IDLE, ACCESS, RESP)
//   - REQ_CORE / REQ_DBG : requester ids (LSU path / debug-loader port)
//   - N_REQ : number of requesters
//   - id_to_onehot : helper turning a requester id into a strobe vector
package mem_arb_pkg;

    parameter int N_REQ = 2;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    function automatic logic [N_REQ-1:0] id_to_onehot(input logic id);
        logic [N_REQ-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2
// Combinational round-robin pick between two requesters.
// Ports:
//   valid [1:0] : request valid vector (bit i = requester i)
//   last        : id of the most recently granted requester
//   grant [1:0] : one-hot grant, all zero when nothing is valid
//   id          : granted requester id (0 when nothing is valid)
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [N_REQ-1:0] valid,
    input  logic             last,
    output logic [N_REQ-1:0] grant,
    output logic             id
);

    always_comb begin
        grant = '0;
        id    = REQ_CORE;
        case (valid)
            2'b01: begin
                id    = REQ_CORE;
                grant = id_to_onehot(REQ_CORE);
            end
            2'b10: begin
                id    = REQ_DBG;
                grant = id_to_onehot(REQ_DBG);
            end
            2'b11: begin
                // Contention: the requester that did not win last time goes.
                id    = ~last;
                grant = id_to_onehot(~last);
            end
            default: begin
                id    = REQ_CORE;
                grant = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbiter and sequencer for the shared single-port data memory behind the
// load/store unit. Requester 0 is the core LSU, requester 1 the debug /
// program-loader port. One transaction is in flight at a time:
//   handshake (cycle N) -> memory access (N+1) -> response strobe (N+2).
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o : per-requester valid/ready handshake
//   req_wren_i, req_addr_i, req_wdata_i, req_bmask_i : per-requester request
//   rsp_valid_o             : one-cycle response strobe toward the owner
//   rsp_err_o, rsp_rdata_o  : out-of-range flag and read data with the strobe
//   mem_en_o, mem_wren_o, mem_addr_o, mem_wdata_o, mem_bmask_o : registered
//                             memory request
//   mem_rdata_i             : memory read data, one cycle after mem_en_o
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_AW = 14,
    parameter int DATA_W = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_REQ-1:0]                req_valid_i,
    output logic [N_REQ-1:0]                req_ready_o,
    input  logic [N_REQ-1:0]                req_wren_i,
    input  logic [N_REQ-1:0][31:0]          req_addr_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]    req_wdata_i,
    input  logic [N_REQ-1:0][DATA_W/8-1:0]  req_bmask_i,
    output logic [N_REQ-1:0]                rsp_valid_o,
    output logic                            rsp_err_o,
    output logic [DATA_W-1:0]               rsp_rdata_o,
    output logic                            mem_en_o,
    output logic                            mem_wren_o,
    output logic [MEM_AW-1:0]               mem_addr_o,
    output logic [DATA_W-1:0]               mem_wdata_o,
    output logic [DATA_W/8-1:0]             mem_bmask_o,
    input  logic [DATA_W-1:0]               mem_rdata_i
);

    localparam int BM_W = DATA_W / 8;

    arb_state_e state_reg, state_next;

    logic               ptr_reg;
    logic               id_reg;
    logic               wren_reg;
    logic               err_reg;
    logic               mem_en_reg;
    logic               mem_wren_reg;
    logic [MEM_AW-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;
    logic [BM_W-1:0]    mem_bmask_reg;

    logic [N_REQ-1:0]   pick_grant;
    logic               pick_id;
    logic [N_REQ-1:0]   req_oob;
    logic               accepting;
    logic               handshake;

    // Per-requester out-of-range decode: any address bit above the memory
    // window makes the access an error.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_oob
            assign req_oob[gi] = |req_addr_i[gi][31:MEM_AW];
        end
    endgenerate

    rr_pick2 u_pick (
        .valid (req_valid_i),
        .last  (ptr_reg),
        .grant (pick_grant),
        .id    (pick_id)
    );

    // New requests are taken only while no access is on the memory port.
    assign accepting = (state_reg == IDLE) || (state_reg == RESP);
    assign handshake = accepting && (|req_valid_i);

    always_comb begin
        state_next  = state_reg;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_err_o   = 1'b0;
        rsp_rdata_o = '0;
        case (state_reg)
            IDLE: begin
                req_ready_o = pick_grant;
                if (|req_valid_i) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid_o = id_to_onehot(id_reg);
                rsp_err_o   = err_reg;
                // Writes and errored reads answer with zero data.
                if (!wren_reg && !err_reg) begin
                    rsp_rdata_o = mem_rdata_i;
                end
                req_ready_o = pick_grant;
                state_next  = (|req_valid_i) ? ACCESS : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture on handshake. The memory-port registers are loaded directly so
    // the request appears on the port in the cycle after the handshake and is
    // cleared again afterwards; an out-of-range access never enables memory.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_reg       <= REQ_DBG;
            id_reg        <= REQ_CORE;
            wren_reg      <= 1'b0;
            err_reg       <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_wren_reg  <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_bmask_reg <= '0;
        end else if (handshake) begin
            ptr_reg       <= pick_id;
            id_reg        <= pick_id;
            wren_reg      <= req_wren_i[pick_id];
            err_reg       <= req_oob[pick_id];
            mem_en_reg    <= !req_oob[pick_id];
            mem_wren_reg  <= !req_oob[pick_id] && req_wren_i[pick_id];
            mem_addr_reg  <= req_addr_i[pick_id][MEM_AW-1:0];
            mem_wdata_reg <= req_wdata_i[pick_id];
            mem_bmask_reg <= req_bmask_i[pick_id];
        end else begin
            mem_en_reg    <= 1'b0;
            mem_wren_reg  <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_bmask_reg <= '0;
        end
    end

    assign mem_en_o    = mem_en_reg;
    assign mem_wren_o  = mem_wren_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;
    assign mem_bmask_o = mem_bmask_reg;

endmodule
